// File: rtl/counter_ctrl.sv
// Host-side MMIO controller for the performance counter: drives state/interval,
// snapshots the counter value, and halts automatically after a programmable run length.
module counter_ctrl #(
    parameter int          CNT_W        = 32,
    parameter int unsigned INTERVAL_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             rvalid,
    output logic [7:0]       state,
    output logic [CNT_W-1:0] interval,
    input  logic [CNT_W-1:0] counter,
    output logic             done
);

    typedef enum logic [7:0] {
        ST_RESET = 8'd0,
        ST_RUN   = 8'd1,
        ST_HALT  = 8'd2
    } state_t;

    localparam logic [1:0] A_CTRL     = 2'd0;
    localparam logic [1:0] A_INTERVAL = 2'd1;
    localparam logic [1:0] A_LIMIT    = 2'd2;
    localparam logic [1:0] A_SNAP     = 2'd3;

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_HALT  = 2'd2;
    localparam logic [1:0] CMD_SNAP  = 2'd3;

    state_t           state_q;
    logic [CNT_W-1:0] run_limit;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] snapshot;
    logic             wr_err;

    logic             ctrl_wr;
    logic [CNT_W:0]   cnt_inc;
    logic             limit_hit;
    logic [CNT_W-1:0] ctrl_word;
    logic [CNT_W-1:0] rd_mux;

    assign state    = state_q;
    assign ctrl_wr  = wr_en && (addr == A_CTRL);

    // Extra bit keeps run_cnt+1 from wrapping past an all-ones limit.
    assign cnt_inc   = {1'b0, run_cnt} + (CNT_W+1)'(1);
    assign limit_hit = (state_q == ST_RUN) && (run_limit != '0) &&
                       (cnt_inc >= {1'b0, run_limit}) && !ctrl_wr;

    always_comb begin
        ctrl_word      = '0;
        ctrl_word[9]   = done;
        ctrl_word[8]   = wr_err;
        ctrl_word[7:0] = state_q;
        rd_mux         = ctrl_word;
        case (addr)
            A_CTRL:     rd_mux = ctrl_word;
            A_INTERVAL: rd_mux = interval;
            A_LIMIT:    rd_mux = run_limit;
            A_SNAP:     rd_mux = snapshot;
            default:    rd_mux = ctrl_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            interval  <= CNT_W'(INTERVAL_RST);
            run_limit <= '0;
            run_cnt   <= '0;
            snapshot  <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            // Read mux sees pre-write register values.
            rvalid <= rd_en;
            if (rd_en)
                rdata <= rd_mux;

            if (state_q == ST_RUN)
                run_cnt <= run_cnt + CNT_W'(1);

            if (limit_hit) begin
                state_q <= ST_HALT;
                done    <= 1'b1;
            end

            if (wr_en) begin
                case (addr)
                    A_CTRL: begin
                        case (wdata[1:0])
                            CMD_RESET: begin
                                state_q  <= ST_RESET;
                                run_cnt  <= '0;
                                done     <= 1'b0;
                                wr_err   <= 1'b0;
                                interval <= CNT_W'(INTERVAL_RST);
                            end
                            CMD_RUN: begin
                                state_q <= ST_RUN;
                                done    <= 1'b0;
                            end
                            CMD_HALT: begin
                                if (state_q == ST_RUN)
                                    state_q <= ST_HALT;
                            end
                            CMD_SNAP: snapshot <= counter;
                            default: ;
                        endcase
                    end
                    A_INTERVAL: begin
                        if (state_q == ST_RUN)
                            wr_err <= 1'b1;
                        else
                            interval <= (wdata == '0) ? CNT_W'(1) : wdata;
                    end
                    A_LIMIT: run_limit <= wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: reads push expected rdata, a monitor pops on rvalid.
module tb_counter_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [1:0]   addr = 2'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] counter = '0;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic [7:0]   state;
    logic [W-1:0] interval;
    logic         done;

    always #5 clk = ~clk;

    counter_ctrl #(.CNT_W(W), .INTERVAL_RST(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .state(state),
        .interval(interval), .counter(counter), .done(done)
    );

    typedef struct {
        logic [W-1:0] val;
        string        tag;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && rvalid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid: got rdata 0x%0h expected no response", rdata);
            end else begin
                x = expq.pop_front();
                chk(x.tag, rdata, x.val);
            end
        end
    end

    // One clock: drive at negedge, return at the next negedge.
    task automatic cyc(input logic w, input logic r, input logic [1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] e, input string tag);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        if (r) expq.push_back('{e, tag});
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        cyc(1'b1, 1'b0, a, d, '0, "");
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] e, input string tag);
        cyc(1'b0, 1'b1, a, '0, e, tag);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, '0, '0, "");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", W'(state), W'(0));
        chk("rst_interval", interval, W'(1));
        chk("rst_done", W'(done), W'(0));
        chk("rst_rvalid", W'(rvalid), W'(0));
        rst = 1'b0;
        rd(2'd0, 'h000, "rst_ctrl_read");

        // Run limit 5: RUN for exactly 5 cycles, then HALT with done
        wr(2'd2, 5);
        wr(2'd0, 1);
        for (int i = 0; i < 5; i++) rd(2'd0, 'h001, "lim5_run");
        rd(2'd0, 'h202, "lim5_halt");
        rd(2'd0, 'h202, "lim5_halt_hold");
        chk("lim5_done_port", W'(done), W'(1));

        // Read-before-write on RUN_LIMIT; go unlimited (run_cnt now 5)
        cyc(1'b1, 1'b1, 2'd2, '0, 5, "rbw_limit");
        rd(2'd2, 0, "limit_cleared");

        // Halt, snapshot, resume
        counter = 'h1234;
        wr(2'd0, 1);
        wr(2'd0, 2);
        wr(2'd0, 3);
        counter = 'h5555;
        wr(2'd3, 'hdead);
        rd(2'd3, 'h1234, "snapshot");
        rd(2'd0, 'h002, "halt_done_clr");
        chk("halt_state_port", W'(state), W'(2));
        // run_cnt held at 6: limit 9 gives only 3 RUN cycles
        wr(2'd2, 9);
        wr(2'd0, 1);
        for (int i = 0; i < 3; i++) rd(2'd0, 'h001, "resume_run");
        rd(2'd0, 'h202, "resume_autohalt");

        // Interval write guard
        wr(2'd1, 7);
        rd(2'd1, 7, "intv_halt_wr");
        chk("intv_port", interval, W'(7));
        wr(2'd2, 0);
        wr(2'd0, 1);
        wr(2'd1, 9);
        rd(2'd1, 7, "intv_run_drop");
        rd(2'd0, 'h101, "wr_err_set");
        wr(2'd0, 2);
        wr(2'd1, 0);
        rd(2'd1, 1, "intv_zero_coerce");
        rd(2'd0, 'h102, "wr_err_sticky");
        wr(2'd1, 7);
        wr(2'd0, 0);
        rd(2'd1, 1, "intv_reload");
        rd(2'd0, 'h000, "ctrl_reset_clr");
        wr(2'd1, 'h20);
        rd(2'd1, 'h20, "intv_reset_wr");

        // Command beats auto-halt (limit 3)
        wr(2'd2, 3);
        wr(2'd0, 1);
        rd(2'd0, 'h001, "cmd_run1");
        rd(2'd0, 'h001, "cmd_run2");
        cyc(1'b1, 1'b1, 2'd0, 1, 'h001, "cmd_run_limit_cycle");
        cyc(1'b1, 1'b1, 2'd0, 2, 'h001, "cmd_run_kept");
        rd(2'd0, 'h002, "cmd_halt_no_done");

        // Mid-operation reset (run_cnt 4 -> 10 over 6 RUN cycles)
        wr(2'd2, 0);
        wr(2'd0, 1);
        repeat (6) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("midrst_state_port", W'(state), W'(0));
        rd(2'd0, 'h000, "midrst_ctrl");
        rd(2'd1, 1, "midrst_interval");
        rd(2'd3, 0, "midrst_snapshot");
        wr(2'd2, 2);
        wr(2'd0, 'hABCD_0005);
        rd(2'd0, 'h001, "midrst_run1");
        rd(2'd0, 'h001, "midrst_run2");
        rd(2'd0, 'h202, "midrst_halt");

        repeat (3) idle();
        chk("queue_drain", W'(expq.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
